map_bmu: RTL and testbench

Branch-metric unit for the 8-state max-log-MAP decoder. It accepts one received systematic/parity/a-priori triple per cycle. For every trellis step it produces the four branch metrics gamma(u,p) that the forward and backward recursions consume, with a block counter and a done pulse that frames each block. It sits directly upstream of the forward-recursion stage.

---
 rtl/map_pkg.sv | 18 +
 rtl/bm_sat.sv | 31 +++
 rtl/map_bmu.sv | 178 +++++++++++++++++
 tb/tb_map_bmu.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/map_pkg.sv
// Shared constants and FSM state type for the max-log-MAP branch-metric unit.
package map_pkg;

    localparam int METRIC_W   = 16;
    localparam int TAIL_LEN   = 3;
    localparam int NUM_STATES = 8;

    localparam logic signed [METRIC_W-1:0] METRIC_MAX = {1'b0, {(METRIC_W-1){1'b1}}};
    localparam logic signed [METRIC_W-1:0] METRIC_MIN = {1'b1, {(METRIC_W-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } bmu_state_e;

endpackage

// File: rtl/bm_sat.sv
// Halves an 18-bit metric sum (floor) and reduces it to METRIC_W bits.
// BMU_SAT_EN defined: saturate to [METRIC_MIN, METRIC_MAX]; undefined: keep the low bits (wrap).
module bm_sat
    import map_pkg::*;
(
    input  logic signed [METRIC_W+1:0] sum_i,
    output logic signed [METRIC_W-1:0] metric_o
);

    logic signed [METRIC_W:0] half;

    // Dropping the LSB of a two's-complement value is an arithmetic shift, i.e. floor(sum/2).
    assign half = sum_i[METRIC_W+1:1];

`ifdef BMU_SAT_EN
    logic unused_bits;
    assign unused_bits = sum_i[0];

    always_comb begin
        metric_o = half[METRIC_W-1:0];
        if (half[METRIC_W] != half[METRIC_W-1]) begin
            metric_o = half[METRIC_W] ? METRIC_MIN : METRIC_MAX;
        end
    end
`else
    logic [1:0] unused_bits;
    assign unused_bits = {half[METRIC_W], sum_i[0]};
    assign metric_o    = half[METRIC_W-1:0];
`endif

endmodule

// File: rtl/map_bmu.sv
// Branch-metric unit for the 8-state max-log-MAP decoder: two-stage pipeline producing gamma(u,p)
// per trellis step, framed by a block FSM. Metric reduction saturates when BMU_SAT_EN is defined.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | accepting samples, step counter advancing
// DRAIN | last sample still in the pipeline (2 cycles)
// DONE  | done_bm pulse, back to IDLE
module map_bmu
    import map_pkg::*;
#(
    parameter int BLK_LEN = 256,
    parameter int IDX_W   = $clog2(BLK_LEN + 3)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [METRIC_W-1:0] ys,
    input  logic signed [METRIC_W-1:0] yp,
    input  logic signed [METRIC_W-1:0] la,
    output logic                       out_valid,
    output logic [IDX_W-1:0]           out_idx,
    output logic                       out_tail,
    output logic signed [METRIC_W-1:0] g00,
    output logic signed [METRIC_W-1:0] g01,
    output logic signed [METRIC_W-1:0] g10,
    output logic signed [METRIC_W-1:0] g11,
    output logic                       done_bm
);

    localparam logic [IDX_W-1:0] LAST_STEP  = IDX_W'(BLK_LEN + TAIL_LEN - 1);
    localparam logic [IDX_W-1:0] TAIL_FIRST = IDX_W'(BLK_LEN);

    bmu_state_e       state_q, state_d;
    logic [IDX_W-1:0] step_q, step_d;
    logic             drain_q, drain_d;
    logic             accept;

    assign accept = in_valid && (state_q == ST_RUN);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            step_q  <= '0;
            drain_q <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            drain_q <= drain_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        drain_d  = drain_q;
        in_ready = 1'b0;
        done_bm  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    step_d  = '0;
                end
            end
            ST_RUN: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    step_d = step_q + 1'b1;
                    if (step_q == LAST_STEP) begin
                        state_d = ST_DRAIN;
                        drain_d = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_q == 1'b0) begin
                    state_d = ST_DONE;
                end else begin
                    drain_d = drain_q - 1'b1;
                end
            end
            ST_DONE: begin
                done_bm = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Stage 1: a-priori masked on tail steps, systematic sum formed at 17 bits.
    logic                       is_tail;
    logic signed [METRIC_W-1:0] la_eff;
    logic signed [METRIC_W:0]   s_d;

    assign is_tail = (step_q >= TAIL_FIRST);
    assign la_eff  = is_tail ? '0 : la;
    assign s_d     = {ys[METRIC_W-1], ys} + {la_eff[METRIC_W-1], la_eff};

    logic                       s1_valid_q;
    logic signed [METRIC_W:0]   s_q;
    logic signed [METRIC_W-1:0] yp_q;
    logic [IDX_W-1:0]           idx1_q;
    logic                       tail1_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_valid_q <= 1'b0;
            s_q        <= '0;
            yp_q       <= '0;
            idx1_q     <= '0;
            tail1_q    <= 1'b0;
        end else begin
            s1_valid_q <= accept;
            if (accept) begin
                s_q     <= s_d;
                yp_q    <= yp;
                idx1_q  <= step_q;
                tail1_q <= is_tail;
            end
        end
    end

    // Stage 2: the four signed combinations at 18 bits, then halve and reduce.
    logic signed [METRIC_W+1:0] sp, ypx;
    logic signed [METRIC_W+1:0] sum00, sum01, sum10, sum11;
    logic signed [METRIC_W-1:0] m00, m01, m10, m11;

    assign sp    = {s_q[METRIC_W], s_q};
    assign ypx   = {{2{yp_q[METRIC_W-1]}}, yp_q};
    assign sum11 = sp + ypx;
    assign sum10 = sp - ypx;
    assign sum01 = ypx - sp;
    assign sum00 = -sp - ypx;

    bm_sat u_sat00 (.sum_i(sum00), .metric_o(m00));
    bm_sat u_sat01 (.sum_i(sum01), .metric_o(m01));
    bm_sat u_sat10 (.sum_i(sum10), .metric_o(m10));
    bm_sat u_sat11 (.sum_i(sum11), .metric_o(m11));

    logic                       out_valid_q;
    logic [IDX_W-1:0]           out_idx_q;
    logic                       out_tail_q;
    logic signed [METRIC_W-1:0] g00_q, g01_q, g10_q, g11_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_tail_q  <= 1'b0;
            g00_q       <= '0;
            g01_q       <= '0;
            g10_q       <= '0;
            g11_q       <= '0;
        end else begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_idx_q  <= idx1_q;
                out_tail_q <= tail1_q;
                g00_q      <= m00;
                g01_q      <= m01;
                g10_q      <= m10;
                g11_q      <= m11;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;
    assign out_tail  = out_tail_q;
    assign g00       = g00_q;
    assign g01       = g01_q;
    assign g10       = g10_q;
    assign g11       = g11_q;

endmodule

// File: tb/tb_map_bmu.sv
// Self-checking bench for map_bmu: directed metric table plus randomized blocks against a
// queue-based reference model. Expected metrics follow BMU_SAT_EN when it is defined.
module tb_map_bmu;

    localparam int BLK_LEN = 256;
    localparam int IDX_W   = 9;
    localparam int NSTEP   = BLK_LEN + 3;

    logic clk = 1'b0;
    logic rst, start, in_valid, in_ready;
    logic signed [15:0] ys, yp, la;
    logic out_valid, out_tail, done_bm;
    logic [IDX_W-1:0] out_idx;
    logic signed [15:0] g00, g01, g10, g11;

    map_bmu #(.BLK_LEN(BLK_LEN), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .ys(ys), .yp(yp), .la(la), .out_valid(out_valid), .out_idx(out_idx),
        .out_tail(out_tail), .g00(g00), .g01(g01), .g10(g10), .g11(g11), .done_bm(done_bm)
    );

    always #5 clk = ~clk;

    // g[] index is 2*u + p
    typedef struct { int cyc; int idx; bit tail; int g[4]; int tab; } exp_t;
    typedef struct { int step; int ys; int yp; int la; bit tail; int g[4]; } vec_t;

    exp_t expq[$];
    vec_t tab[6];

    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    bit  m_ready = 0;
    bit  m_busy = 0;
    int  m_step = 0;
    int  done_at = -1;
    bit  zero_chk = 0;
    int  vcount = 0;

    function automatic int reduce(int v);
        int w;
`ifdef BMU_SAT_EN
        w = v;
        if (v > 32767) w = 32767;
        if (v < -32768) w = -32768;
`else
        w = v & 32'hFFFF;
        if (w >= 32768) w = w - 65536;
`endif
        return w;
    endfunction

    function automatic int ref_metric(int u, int p, int y_s, int y_p, int l_a, bit tail);
        int s, v;
        s = y_s + (tail ? 0 : l_a);
        v = (u != 0 ? s : -s) + (p != 0 ? y_p : -y_p);
        return reduce(v >>> 1);
    endfunction

    function automatic int rnd16();
        logic signed [15:0] r;
        r = 16'($urandom);
        return int'(r);
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic set_tab(int k, int step, int y_s, int y_p, int l_a, bit tail,
                           int e00, int e01, int e10, int e11);
        tab[k].step = step; tab[k].ys = y_s; tab[k].yp = y_p; tab[k].la = l_a;
        tab[k].tail = tail;
        tab[k].g[0] = e00; tab[k].g[1] = e01; tab[k].g[2] = e10; tab[k].g[3] = e11;
    endtask

    // One clock cycle: drive inputs, check outputs at the falling edge, advance the model.
    task automatic do_cycle(bit st, bit v, int a, int b, int c, bit rst_v = 1'b1, int ti = -1);
        exp_t e;
        int   act_g[4];
        bit   exp_v;
        @(posedge clk);
        #1;
        rst = rst_v; start = st; in_valid = v;
        ys = 16'(a); yp = 16'(b); la = 16'(c);
        @(negedge clk);
        act_g[0] = int'(g00); act_g[1] = int'(g01); act_g[2] = int'(g10); act_g[3] = int'(g11);
        chk("in_ready", int'(in_ready), int'(m_ready));
        exp_v = (expq.size() > 0) && (expq[0].cyc == cyc);
        chk("out_valid", int'(out_valid), int'(exp_v));
        if (exp_v) begin
            e = expq.pop_front();
            chk("out_idx", int'(out_idx), e.idx);
            chk("out_tail", int'(out_tail), int'(e.tail));
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("g%0d%0d", i / 2, i % 2), act_g[i], e.g[i]);
                if (e.tab >= 0)
                    chk($sformatf("tab%0d_g%0d%0d", e.tab, i / 2, i % 2), act_g[i], tab[e.tab].g[i]);
            end
            if (e.tab >= 0) chk($sformatf("tab%0d_tail", e.tab), int'(out_tail), int'(tab[e.tab].tail));
        end
        if (out_valid) vcount++;
        chk("done_bm", int'(done_bm), int'(cyc == done_at));
        if (zero_chk) begin
            chk("rst_out_idx", int'(out_idx), 0);
            chk("rst_out_tail", int'(out_tail), 0);
            for (int i = 0; i < 4; i++) chk($sformatf("rst_g%0d", i), act_g[i], 0);
            zero_chk = 0;
        end
        if (!rst_v) begin
            expq.delete();
            m_ready = 0; m_busy = 0; done_at = -1; zero_chk = 1;
        end else begin
            if (m_ready && v) begin
                e.cyc  = cyc + 2;
                e.idx  = m_step;
                e.tail = (m_step >= BLK_LEN);
                e.tab  = ti;
                for (int i = 0; i < 4; i++) e.g[i] = ref_metric(i / 2, i % 2, a, b, c, e.tail);
                expq.push_back(e);
                m_step++;
                if (m_step == NSTEP) begin
                    m_ready = 0;
                    done_at = cyc + 3;
                end
            end
            if (st && !m_busy) begin
                m_busy = 1; m_ready = 1; m_step = 0;
            end else if (cyc == done_at) begin
                m_busy = 0;
            end
        end
        cyc++;
    endtask

    // mode 0: continuous, table vectors, start during RUN; 1: random bubbles; 2: reset at step 100
    task automatic run_block(int mode);
        int acc, guard, a, b, c, ti;
        bit v, st;
        acc = 0; guard = 0; vcount = 0;
        do_cycle(1'b1, 1'b0, 0, 0, 0);
        while (acc < NSTEP && guard < 2000) begin
            guard++;
            a = rnd16(); b = rnd16(); c = rnd16();
            ti = -1; st = 1'b0; v = 1'b1;
            if (mode == 1) v = (guard <= 4) ? guard[0] : 1'($urandom_range(0, 1));
            if (mode == 0) begin
                for (int k = 0; k < 6; k++) begin
                    if (tab[k].step == acc) begin
                        ti = k; a = tab[k].ys; b = tab[k].yp; c = tab[k].la;
                    end
                end
                if (acc == 50) st = 1'b1;
            end
            if (mode == 2 && acc == 100) begin
                do_cycle(1'b0, 1'b1, a, b, c, 1'b0);
                return;
            end
            do_cycle(st, v, a, b, c, 1'b1, ti);
            if (v) acc++;
        end
    endtask

    task automatic finish_block(bit st, int exp_cnt);
        bit got;
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            do_cycle(st, 1'b0, 0, 0, 0);
            if (done_bm) got = 1;
        end
        chk("done_seen", int'(got), 1);
        chk("valid_count", vcount, exp_cnt);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; in_valid = 1'b0; ys = '0; yp = '0; la = '0;

        set_tab(0, 0, 100, 50, 20, 1'b0, -85, -35, 35, 85);
        set_tab(1, 1, -3, 0, 0, 1'b0, 1, 1, -2, -2);
`ifdef BMU_SAT_EN
        set_tab(2, 2, 32767, 32767, 32767, 1'b0, -32768, -16384, 16383, 32767);
        set_tab(3, 3, -32768, -32768, -32768, 1'b0, 32767, 16384, -16384, -32768);
`else
        set_tab(2, 2, 32767, 32767, 32767, 1'b0, 16385, -16384, 16383, -16386);
        set_tab(3, 3, -32768, -32768, -32768, 1'b0, -16384, 16384, -16384, 16384);
`endif
        set_tab(4, 256, -7, 2, 500, 1'b1, 2, 4, -5, -3);
        set_tab(5, 257, 10, 0, 1000, 1'b1, -5, -5, 5, 5);

        repeat (3) do_cycle(1'b0, 1'b0, 0, 0, 0, 1'b0);
        repeat (2) do_cycle(1'b0, 1'b0, 0, 0, 0);

        run_block(0);
        finish_block(1'b0, NSTEP);
        repeat (4) do_cycle(1'b0, 1'b0, 0, 0, 0);

        run_block(1);
        finish_block(1'b1, NSTEP);
        repeat (4) do_cycle(1'b0, 1'b0, 0, 0, 0);

        run_block(2);
        repeat (3) do_cycle(1'b0, 1'b0, 0, 0, 0);

        run_block(0);
        finish_block(1'b0, NSTEP);
        repeat (3) do_cycle(1'b0, 1'b0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
